operand_entry_ctrl: RTL and testbench

//  Parametrised keypad-style operand entry for the calculator top. Debounces the five push buttons and edits a

---
 rtl/operand_entry_ctrl_pkg.sv | 36 +++
 rtl/operand_entry_ctrl_if.sv | 14 +
 rtl/operand_entry_ctrl_btn_debounce.sv | 100 ++++++++++
 rtl/operand_entry_ctrl.sv | 176 +++++++++++++++++
 tb/tb_operand_entry_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/operand_entry_ctrl_pkg.sv
// Shared types and constants for the keypad operand entry block.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package calc_pkg;

    typedef enum logic [1:0] {
        ENTRY   = 2'd0,
        CONVERT = 2'd1,
        VALID   = 2'd2
    } entry_state_t;

    // Button bit positions in the press vector
    localparam int BTN_U   = 0;
    localparam int BTN_D   = 1;
    localparam int BTN_L   = 2;
    localparam int BTN_R   = 3;
    localparam int BTN_C   = 4;
    localparam int BTN_NUM = 5;

    // Every digit is stored in a nibble regardless of radix
    localparam int DIGIT_W = 4;

    // True when the largest entry RADIX**DIGITS-1 fits in an operand of 'width' bits
    function automatic bit operand_fits(input int radix, input int digits, input int width);
        longint unsigned max_val;
        max_val = 64'd1;
        for (int i = 0; i < digits; i++) begin
            max_val = max_val * 64'(radix);
        end
        if (width >= 64) begin
            return 1'b1;
        end
        return (max_val - 64'd1) < (64'd1 << width);
    endfunction

endpackage

// File: rtl/operand_entry_ctrl_if.sv
// Operand-set handshake between the entry block and the ALU stage.
// Latency: n/a (wires only).
// Backpressure: producer holds op_valid and operands_o until op_ready is seen.
interface operand_entry_ctrl_if #(
    parameter int NUM_OPERANDS = 2,
    parameter int OPERAND_W    = 16
);
    logic                              op_valid;
    logic                              op_ready;
    logic [NUM_OPERANDS*OPERAND_W-1:0] operands_o;

    modport master (output op_valid, output operands_o, input op_ready);
    modport slave  (input op_valid, input operands_o, output op_ready);
endinterface

// File: rtl/operand_entry_ctrl_btn_debounce.sv
// Button conditioner: 2-flop synchroniser, stable-level filter, one-clock press pulse, optional auto-repeat (AUTO_REPEAT_EN).
// Latency: press pulse DEBOUNCE_CYCLES+3 clocks after the raw rising edge.
// Backpressure: none; pulses are fire-and-forget and the consumer may drop them.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 50_000,
    parameter int REPEAT_DELAY    = 50_000_000,
    parameter int REPEAT_CYCLES   = 20_000_000,
    parameter bit REPEAT_EN       = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic press_o
);
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1 || (REPEAT_EN && (REPEAT_DELAY < 1 || REPEAT_CYCLES < 1))) begin : g_bad_cfg
        $error("btn_debounce: debounce/repeat intervals must be at least 1");
    end

    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q;
    logic             prev_q;
    logic [CNT_W-1:0] db_cnt_q;
    logic             edge_q;

    // Bring the raw button into the clock domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
        end
    end

    // Accept a new level only after it has held for DEBOUNCE_CYCLES clocks
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt_q <= '0;
            stable_q <= 1'b0;
        end else if (sync2_q == stable_q) begin
            db_cnt_q <= '0;
        end else if (db_cnt_q == CNT_LAST) begin
            db_cnt_q <= '0;
            stable_q <= sync2_q;
        end else begin
            db_cnt_q <= db_cnt_q + 1'b1;
        end
    end

    // One-clock pulse on an accepted 0->1 transition
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 1'b0;
            edge_q <= 1'b0;
        end else begin
            prev_q <= stable_q;
            edge_q <= stable_q & ~prev_q;
        end
    end

`ifdef AUTO_REPEAT_EN
    logic [31:0] rpt_cnt_q;
    logic        rpt_phase_q;
    logic        rpt_q;
    logic [31:0] rpt_last;

    // First repeat waits REPEAT_DELAY, later ones every REPEAT_CYCLES
    assign rpt_last = rpt_phase_q ? 32'(REPEAT_CYCLES - 1) : 32'(REPEAT_DELAY - 1);

    // Repeat timer runs only while the debounced level is high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_cnt_q   <= '0;
            rpt_phase_q <= 1'b0;
            rpt_q       <= 1'b0;
        end else if (!REPEAT_EN || !stable_q) begin
            rpt_cnt_q   <= '0;
            rpt_phase_q <= 1'b0;
            rpt_q       <= 1'b0;
        end else if (rpt_cnt_q == rpt_last) begin
            rpt_cnt_q   <= '0;
            rpt_phase_q <= 1'b1;
            rpt_q       <= 1'b1;
        end else begin
            rpt_cnt_q   <= rpt_cnt_q + 32'd1;
            rpt_q       <= 1'b0;
        end
    end

    assign press_o = edge_q | rpt_q;
`else
    assign press_o = edge_q;
`endif

endmodule

// File: rtl/operand_entry_ctrl.sv
// Keypad operand entry: edits a radix-RADIX digit register, Horner-converts each commit, collects NUM_OPERANDS operands (AUTO_REPEAT_EN adds U/D auto-repeat).
// Latency: DIGITS clocks in CONVERT per commit; op_valid the clock after the last slot is written.
// Backpressure: op_valid/operands_o held until op_ready; presses arriving in CONVERT or VALID are dropped.
module operand_entry_ctrl
    import calc_pkg::*;
#(
    parameter int DIGITS          = 4,
    parameter int RADIX           = 10,
    parameter int NUM_OPERANDS    = 2,
    parameter int OPERAND_W       = 16,
    parameter int DEBOUNCE_CYCLES = 50_000,
    parameter int REPEAT_DELAY    = 50_000_000,
    parameter int REPEAT_CYCLES   = 20_000_000
) (
    input  logic                      CLK100MHZ,
    input  logic                      rst_n,
    input  logic                      btnU,
    input  logic                      btnD,
    input  logic                      btnL,
    input  logic                      btnR,
    input  logic                      btnC,
    input  logic                      clear,
    output logic [DIGIT_W*DIGITS-1:0] digits_o,
    output logic [1:0]                operand_idx,
    output logic                      busy,
    operand_entry_ctrl_if.master      alu
);
    localparam int DW     = DIGIT_W * DIGITS;
    localparam int SW     = NUM_OPERANDS * OPERAND_W;
    localparam int DIDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [DIGIT_W-1:0]   DIG_MAX  = DIGIT_W'(RADIX - 1);
    localparam logic [OPERAND_W-1:0] RADIX_OP = OPERAND_W'(RADIX);
    localparam logic [1:0]           LAST_IDX = 2'(NUM_OPERANDS - 1);
    localparam logic [DIDX_W-1:0]    MSD_IDX  = DIDX_W'(DIGITS - 1);

    if (DIGITS < 1 || DIGITS > 8 || RADIX < 2 || RADIX > 16 ||
        NUM_OPERANDS < 1 || NUM_OPERANDS > 4) begin : g_bad_cfg
        $error("operand_entry_ctrl: DIGITS/RADIX/NUM_OPERANDS out of range");
    end
    if (!operand_fits(RADIX, DIGITS, OPERAND_W)) begin : g_bad_width
        $error("operand_entry_ctrl: OPERAND_W too narrow for RADIX**DIGITS-1");
    end

    entry_state_t        state_q, state_d;
    logic [DW-1:0]       digits_q, digits_d;
    logic [OPERAND_W-1:0] acc_q, acc_d;
    logic [DIDX_W-1:0]   cidx_q, cidx_d;
    logic [1:0]          idx_q, idx_d;
    logic [SW-1:0]       slots_q, slots_d;

    logic [BTN_NUM-1:0]   raw_btn;
    logic [BTN_NUM-1:0]   press;
    logic [DIGIT_W-1:0]   d0;
    logic [DIGIT_W-1:0]   cur_digit;
    logic [OPERAND_W-1:0] acc_next;
    logic                 conv_last;
    logic                 op_valid;

    assign raw_btn = {btnC, btnR, btnL, btnD, btnU};

    for (genvar i = 0; i < BTN_NUM; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_CYCLES   (REPEAT_CYCLES),
            .REPEAT_EN       ((i == BTN_U) || (i == BTN_D))
        ) u_db (
            .clk     (CLK100MHZ),
            .rst_n   (rst_n),
            .btn_i   (raw_btn[i]),
            .press_o (press[i])
        );
    end

    // Horner step: MSD first, cidx_q walks down to digit 0
    assign d0        = digits_q[DIGIT_W-1:0];
    assign cur_digit = digits_q[cidx_q*DIGIT_W +: DIGIT_W];
    assign acc_next  = acc_q * RADIX_OP + OPERAND_W'(cur_digit);
    assign conv_last = (cidx_q == '0);

    // FSM state register
    always_ff @(posedge CLK100MHZ or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ENTRY;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; clear overrides every other event
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ENTRY;
        end else begin
            case (state_q)
                ENTRY:   if (press[BTN_C]) state_d = CONVERT;
                CONVERT: if (conv_last) state_d = (idx_q == LAST_IDX) ? VALID : ENTRY;
                VALID:   if (alu.op_ready) state_d = ENTRY;
                default: state_d = ENTRY;
            endcase
        end
    end

    // FSM outputs
    always_comb begin
        op_valid = (state_q == VALID);
        busy     = (state_q == CONVERT);
    end

    // Datapath next state: digit edits by priority C > L > R > U > D, conversion, slot write
    always_comb begin
        digits_d = digits_q;
        acc_d    = acc_q;
        cidx_d   = cidx_q;
        idx_d    = idx_q;
        slots_d  = slots_q;
        if (clear) begin
            digits_d = '0;
            idx_d    = '0;
        end else begin
            case (state_q)
                ENTRY: begin
                    if (press[BTN_C]) begin
                        acc_d  = '0;
                        cidx_d = MSD_IDX;
                    end else if (press[BTN_L]) begin
                        digits_d = digits_q << DIGIT_W;
                    end else if (press[BTN_R]) begin
                        digits_d = digits_q >> DIGIT_W;
                    end else if (press[BTN_U]) begin
                        digits_d[DIGIT_W-1:0] = (d0 == DIG_MAX) ? '0 : d0 + 1'b1;
                    end else if (press[BTN_D]) begin
                        digits_d[DIGIT_W-1:0] = (d0 == '0) ? DIG_MAX : d0 - 1'b1;
                    end
                end
                CONVERT: begin
                    acc_d  = acc_next;
                    cidx_d = cidx_q - 1'b1;
                    if (conv_last) begin
                        slots_d[idx_q*OPERAND_W +: OPERAND_W] = acc_next;
                        digits_d = '0;
                        idx_d    = idx_q + 2'd1;
                    end
                end
                VALID: begin
                    if (alu.op_ready) idx_d = '0;
                end
                default: ;
            endcase
        end
    end

    // Datapath registers
    always_ff @(posedge CLK100MHZ or negedge rst_n) begin
        if (!rst_n) begin
            digits_q <= '0;
            acc_q    <= '0;
            cidx_q   <= '0;
            idx_q    <= '0;
            slots_q  <= '0;
        end else begin
            digits_q <= digits_d;
            acc_q    <= acc_d;
            cidx_q   <= cidx_d;
            idx_q    <= idx_d;
            slots_q  <= slots_d;
        end
    end

    assign digits_o       = digits_q;
    assign operand_idx    = idx_q;
    assign alu.op_valid   = op_valid;
    assign alu.operands_o = slots_q;

endmodule

// File: tb/tb_operand_entry_ctrl.sv
// Self-checking bench for operand_entry_ctrl with short debounce/repeat intervals.
// Latency: n/a.
// Backpressure: op_ready driven by the bench.
module tb_operand_entry_ctrl;
    import calc_pkg::*;

    localparam int DIGITS = 4;
    localparam int RADIX  = 10;
    localparam int NOPS   = 2;
    localparam int OPW    = 16;
    localparam int DEB    = 100;
    localparam int RDLY   = 1000;
    localparam int RCYC   = 200;
    localparam int HOLD   = 200;
    localparam int GAP    = 200;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btnU = 1'b0, btnD = 1'b0, btnL = 1'b0, btnR = 1'b0, btnC = 1'b0;
    logic clear = 1'b0;
    logic [15:0] digits_o;
    logic [1:0]  operand_idx;
    logic        busy;

    operand_entry_ctrl_if #(.NUM_OPERANDS(NOPS), .OPERAND_W(OPW)) alu_if ();

    operand_entry_ctrl #(
        .DIGITS(DIGITS), .RADIX(RADIX), .NUM_OPERANDS(NOPS), .OPERAND_W(OPW),
        .DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(RDLY), .REPEAT_CYCLES(RCYC)
    ) dut (
        .CLK100MHZ(clk), .rst_n(rst_n),
        .btnU(btnU), .btnD(btnD), .btnL(btnL), .btnR(btnR), .btnC(btnC),
        .clear(clear), .digits_o(digits_o), .operand_idx(operand_idx),
        .busy(busy), .alu(alu_if)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model of the entry register and operand slots
    int          m_dig [DIGITS];
    int          m_idx;
    logic [15:0] m_slot [NOPS];

    typedef struct { int idx; logic [15:0] val; } slot_exp_t;
    slot_exp_t   sb_slot [$];
    logic [31:0] sb_set [$];

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] model_word();
        logic [15:0] w;
        w = '0;
        for (int i = 0; i < DIGITS; i++) w[4*i +: 4] = 4'(m_dig[i]);
        return w;
    endfunction

    function automatic int model_value();
        int v;
        v = 0;
        for (int i = DIGITS - 1; i >= 0; i--) v = v * RADIX + m_dig[i];
        return v;
    endfunction

    function automatic void model_zero_digits();
        for (int i = 0; i < DIGITS; i++) m_dig[i] = 0;
    endfunction

    function automatic void model_edit(input int b);
        case (b)
            BTN_U: m_dig[0] = (m_dig[0] + 1) % RADIX;
            BTN_D: m_dig[0] = (m_dig[0] + RADIX - 1) % RADIX;
            BTN_L: begin
                for (int i = DIGITS - 1; i > 0; i--) m_dig[i] = m_dig[i-1];
                m_dig[0] = 0;
            end
            BTN_R: begin
                for (int i = 0; i < DIGITS - 1; i++) m_dig[i] = m_dig[i+1];
                m_dig[DIGITS-1] = 0;
            end
            default: ;
        endcase
    endfunction

    // Queue the expected slot write for a commit and advance the model
    function automatic void model_commit();
        slot_exp_t e;
        e.idx = m_idx;
        e.val = 16'(model_value());
        sb_slot.push_back(e);
        m_slot[m_idx] = e.val;
        m_idx = m_idx + 1;
        model_zero_digits();
        if (m_idx == NOPS) sb_set.push_back({m_slot[1], m_slot[0]});
    endfunction

    function automatic void model_reset();
        model_zero_digits();
        m_idx = 0;
        for (int i = 0; i < NOPS; i++) m_slot[i] = '0;
    endfunction

    task automatic set_btn(input int b, input logic v);
        case (b)
            BTN_U: btnU = v;
            BTN_D: btnD = v;
            BTN_L: btnL = v;
            BTN_R: btnR = v;
            default: btnC = v;
        endcase
    endtask

    task automatic press(input int b, input int hold);
        set_btn(b, 1'b1);
        tick(hold);
        set_btn(b, 1'b0);
        tick(GAP);
    endtask

    // Drive a commit; u_delay<0 no U, 0 U with C, >0 U that many clocks after C
    task automatic commit_drive(input int u_delay, output bit saw_busy, output int busy_cyc);
        saw_busy = 1'b0;
        busy_cyc = 0;
        btnC = 1'b1;
        if (u_delay == 0) btnU = 1'b1;
        else if (u_delay > 0) begin
            tick(u_delay);
            btnU = 1'b1;
        end
        for (int i = 0; i < DEB + 20 && !busy; i++) tick(1);
        if (busy) saw_busy = 1'b1;
        while (busy && busy_cyc < DIGITS + 4) begin
            busy_cyc++;
            tick(1);
        end
        tick(HOLD);
        btnC = 1'b0;
        btnU = 1'b0;
        tick(GAP);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(3);
        n_cmp++; if (digits_o !== 16'h0) begin n_err++; $display("FAIL rst_digits: got %h want 0", digits_o); end
        n_cmp++; if (operand_idx !== 2'd0) begin n_err++; $display("FAIL rst_idx: got %0d want 0", operand_idx); end
        n_cmp++; if (alu_if.op_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", alu_if.op_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_cmp++; if (alu_if.operands_o !== 32'h0) begin n_err++; $display("FAIL rst_operands: got %h want 0", alu_if.operands_o); end
        rst_n = 1'b1;
        model_reset();
        tick(GAP);
    endtask

    task automatic test_entry_convert();
        bit saw;
        int cyc;
        slot_exp_t e;
        int seq [3] = '{BTN_U, BTN_L, BTN_U};
        for (int k = 0; k < 3; k++) begin
            press(seq[k], HOLD);
            model_edit(seq[k]);
            n_cmp++; if (digits_o !== model_word()) begin n_err++; $display("FAIL entry_step%0d: digits %h want %h", k, digits_o, model_word()); end
        end
        model_commit();
        commit_drive(-1, saw, cyc);
        e = sb_slot.pop_front();
        n_cmp++; if (saw !== 1'b1) begin n_err++; $display("FAIL conv_start: busy never rose"); end
        n_cmp++; if (cyc !== DIGITS) begin n_err++; $display("FAIL conv_len: busy %0d clocks want %0d", cyc, DIGITS); end
        n_cmp++; if (alu_if.operands_o[e.idx*16 +: 16] !== e.val) begin n_err++; $display("FAIL conv_slot0: got %0d want %0d", alu_if.operands_o[e.idx*16 +: 16], e.val); end
        n_cmp++; if (digits_o !== model_word()) begin n_err++; $display("FAIL conv_digits: got %h want %h", digits_o, model_word()); end
        n_cmp++; if (operand_idx !== 2'(m_idx)) begin n_err++; $display("FAIL conv_idx: got %0d want %0d", operand_idx, m_idx); end
    endtask

    task automatic test_valid_handshake();
        bit saw;
        int cyc;
        int xfers;
        bit held;
        slot_exp_t e;
        logic [31:0] exp_set;
        alu_if.op_ready = 1'b0;
        press(BTN_U, HOLD); model_edit(BTN_U);
        press(BTN_L, HOLD); model_edit(BTN_L);
        model_commit();
        commit_drive(-1, saw, cyc);
        e = sb_slot.pop_front();
        n_cmp++; if (alu_if.operands_o[e.idx*16 +: 16] !== e.val) begin n_err++; $display("FAIL hs_slot1: got %0d want %0d", alu_if.operands_o[e.idx*16 +: 16], e.val); end
        n_cmp++; if (alu_if.op_valid !== 1'b1) begin n_err++; $display("FAIL hs_valid: got %b want 1", alu_if.op_valid); end
        exp_set = sb_set.pop_front();
        n_cmp++; if (alu_if.operands_o !== exp_set) begin n_err++; $display("FAIL hs_set: got %h want %h", alu_if.operands_o, exp_set); end
        held = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (alu_if.op_valid !== 1'b1 || alu_if.operands_o !== exp_set) held = 1'b0;
            tick(1);
        end
        n_cmp++; if (held !== 1'b1) begin n_err++; $display("FAIL hs_hold: valid/operands not stable, now %b %h", alu_if.op_valid, alu_if.operands_o); end
        alu_if.op_ready = 1'b1;
        xfers = 0;
        for (int i = 0; i < 10; i++) begin
            if (alu_if.op_valid && alu_if.op_ready) xfers++;
            tick(1);
        end
        alu_if.op_ready = 1'b0;
        m_idx = 0;
        n_cmp++; if (xfers !== 1) begin n_err++; $display("FAIL hs_xfers: got %0d want 1", xfers); end
        n_cmp++; if (alu_if.op_valid !== 1'b0) begin n_err++; $display("FAIL hs_drop: op_valid %b want 0", alu_if.op_valid); end
        n_cmp++; if (operand_idx !== 2'd0) begin n_err++; $display("FAIL hs_idx: got %0d want 0", operand_idx); end
        n_cmp++; if (alu_if.operands_o !== exp_set) begin n_err++; $display("FAIL hs_keep: got %h want %h", alu_if.operands_o, exp_set); end
    endtask

    task automatic test_wrap_shift();
        int build [6] = '{BTN_L, BTN_D, BTN_L, BTN_D, BTN_L, BTN_D};
        press(BTN_D, HOLD); model_edit(BTN_D);
        n_cmp++; if (digits_o !== model_word()) begin n_err++; $display("FAIL wrap_down: got %h want %h", digits_o, model_word()); end
        for (int k = 0; k < 6; k++) begin
            press(build[k], HOLD);
            model_edit(build[k]);
        end
        n_cmp++; if (digits_o !== model_word()) begin n_err++; $display("FAIL build_9999: got %h want %h", digits_o, model_word()); end
        press(BTN_L, HOLD); model_edit(BTN_L);
        n_cmp++; if (digits_o !== model_word()) begin n_err++; $display("FAIL shift_left: got %h want %h", digits_o, model_word()); end
        btnU = 1'b1; tick(50); btnU = 1'b0; tick(GAP);
        btnL = 1'b1; tick(50); btnL = 1'b0; tick(GAP);
        n_cmp++; if (digits_o !== model_word()) begin n_err++; $display("FAIL glitch: got %h want %h", digits_o, model_word()); end
        press(BTN_R, HOLD); model_edit(BTN_R);
        n_cmp++; if (digits_o !== model_word()) begin n_err++; $display("FAIL shift_right: got %h want %h", digits_o, model_word()); end
        press(BTN_U, HOLD); model_edit(BTN_U);
        n_cmp++; if (digits_o !== model_word()) begin n_err++; $display("FAIL wrap_up: got %h want %h", digits_o, model_word()); end
    endtask

    task automatic test_same_cycle();
        bit saw;
        int cyc;
        slot_exp_t e;
        model_commit();
        commit_drive(0, saw, cyc);
        e = sb_slot.pop_front();
        n_cmp++; if (alu_if.operands_o[e.idx*16 +: 16] !== e.val) begin n_err++; $display("FAIL uc_slot: got %0d want %0d", alu_if.operands_o[e.idx*16 +: 16], e.val); end
        n_cmp++; if (operand_idx !== 2'(m_idx)) begin n_err++; $display("FAIL uc_idx: got %0d want %0d", operand_idx, m_idx); end
        model_commit();
        commit_drive(2, saw, cyc);
        e = sb_slot.pop_front();
        void'(sb_set.pop_front());
        n_cmp++; if (alu_if.operands_o[e.idx*16 +: 16] !== e.val) begin n_err++; $display("FAIL uconv_slot: got %0d want %0d", alu_if.operands_o[e.idx*16 +: 16], e.val); end
        n_cmp++; if (digits_o !== model_word()) begin n_err++; $display("FAIL uconv_digits: got %h want %h", digits_o, model_word()); end
        n_cmp++; if (alu_if.op_valid !== 1'b1) begin n_err++; $display("FAIL uconv_valid: got %b want 1", alu_if.op_valid); end
    endtask

    task automatic test_clear_reset();
        bit saw;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (alu_if.op_valid !== 1'b0) begin n_err++; $display("FAIL arst_valid: got %b want 0", alu_if.op_valid); end
        n_cmp++; if (alu_if.operands_o !== 32'h0) begin n_err++; $display("FAIL arst_operands: got %h want 0", alu_if.operands_o); end
        n_cmp++; if (operand_idx !== 2'd0) begin n_err++; $display("FAIL arst_idx: got %0d want 0", operand_idx); end
        n_cmp++; if (busy !== 1'b0 || digits_o !== 16'h0) begin n_err++; $display("FAIL arst_misc: busy %b digits %h want 0 0", busy, digits_o); end
        tick(2);
        rst_n = 1'b1;
        model_reset();
        tick(GAP);
        press(BTN_U, HOLD); model_edit(BTN_U);
        btnC = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < DEB + 20 && !busy; i++) tick(1);
        if (busy) saw = 1'b1;
        n_cmp++; if (saw !== 1'b1) begin n_err++; $display("FAIL clr_start: busy never rose"); end
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        model_zero_digits();
        m_idx = 0;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL clr_busy: got %b want 0", busy); end
        n_cmp++; if (digits_o !== model_word()) begin n_err++; $display("FAIL clr_digits: got %h want %h", digits_o, model_word()); end
        n_cmp++; if (operand_idx !== 2'(m_idx)) begin n_err++; $display("FAIL clr_idx: got %0d want %0d", operand_idx, m_idx); end
        tick(HOLD);
        btnC = 1'b0;
        tick(GAP);
        n_cmp++; if (alu_if.operands_o !== {m_slot[1], m_slot[0]}) begin n_err++; $display("FAIL clr_noslot: got %h want %h", alu_if.operands_o, {m_slot[1], m_slot[0]}); end
    endtask

    task automatic test_auto_repeat();
        int n_inc;
`ifdef AUTO_REPEAT_EN
        n_inc = 4;
`else
        n_inc = 1;
`endif
        press(BTN_U, 1500);
        for (int i = 0; i < n_inc; i++) model_edit(BTN_U);
        n_cmp++; if (digits_o !== model_word()) begin n_err++; $display("FAIL repeat: got %h want %h", digits_o, model_word()); end
    endtask

    initial begin
        alu_if.op_ready = 1'b0;
        model_reset();
        test_reset();
        test_entry_convert();
        test_valid_handshake();
        test_wrap_shift();
        test_same_cycle();
        test_clear_reset();
        test_auto_repeat();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
